// File: rtl/amo_unit_pkg.sv
// Shared definitions for the atomic memory operation unit: funct5 codes,
// FSM state encoding and D-cache access size codes.
package amo_unit_pkg;

    // funct5 encodings of the RV64A operations
    localparam logic [4:0] AMO_ADD  = 5'b00000;
    localparam logic [4:0] AMO_SWAP = 5'b00001;
    localparam logic [4:0] AMO_LR   = 5'b00010;
    localparam logic [4:0] AMO_SC   = 5'b00011;
    localparam logic [4:0] AMO_XOR  = 5'b00100;
    localparam logic [4:0] AMO_NONE = 5'b00101;
    localparam logic [4:0] AMO_OR   = 5'b01000;
    localparam logic [4:0] AMO_AND  = 5'b01100;
    localparam logic [4:0] AMO_MIN  = 5'b10000;
    localparam logic [4:0] AMO_MAX  = 5'b10100;
    localparam logic [4:0] AMO_MINU = 5'b11000;
    localparam logic [4:0] AMO_MAXU = 5'b11100;

    // D-cache access size codes
    localparam logic [1:0] DC_SIZE_W = 2'd2;
    localparam logic [1:0] DC_SIZE_D = 2'd3;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_RWAIT = 3'd2,
        S_WR    = 3'd3,
        S_DONE  = 3'd4
    } amo_state_e;

    // True for every funct5 this unit executes
    function automatic logic is_supported(input logic [4:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            AMO_ADD, AMO_SWAP, AMO_LR, AMO_SC, AMO_XOR, AMO_OR, AMO_AND,
            AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/amo_unit_alu.sv
// Combinational read-modify-write datapath: computes the value written back
// to memory from the loaded value and rs2.
module amo_alu
    import amo_unit_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [4:0]      op,
    input  logic            op_32,
    input  logic [XLEN-1:0] loaded,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] new_val
);

    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            lt_s;
    logic            lt_u;

    // Word ops sign-extend both operands; sign extension preserves both the
    // signed and the unsigned ordering of 32-bit values, and the low word of
    // a 64-bit sum equals the 32-bit sum, so one datapath serves both widths.
    always_comb begin
        a = loaded;
        b = rs2;
        if (op_32) begin
            a = {{(XLEN-32){loaded[31]}}, loaded[31:0]};
            b = {{(XLEN-32){rs2[31]}}, rs2[31:0]};
        end
        lt_s = $signed(a) < $signed(b);
        lt_u = a < b;
    end

    // Operation select
    always_comb begin
        new_val = b;
        case (op)
            AMO_ADD:  new_val = a + b;
            AMO_SWAP: new_val = b;
            AMO_XOR:  new_val = a ^ b;
            AMO_OR:   new_val = a | b;
            AMO_AND:  new_val = a & b;
            AMO_MIN:  new_val = lt_s ? a : b;
            AMO_MAX:  new_val = lt_s ? b : a;
            AMO_MINU: new_val = lt_u ? a : b;
            AMO_MAXU: new_val = lt_u ? b : a;
            default:  new_val = b;
        endcase
    end

endmodule

// File: rtl/amo_unit.sv
// RV64A atomic sequencer: LR/SC with a single reservation and AMO
// read-modify-write over the D-cache port. Holds the pipeline via BUSY and
// returns rd with a one-cycle RESULT_VALID pulse.
//
// Cache handshake: DC_REQ is held high with stable DC_ADDR/DC_SIZE/DC_WDATA
// until a cycle in which DC_GNT is high; that cycle transfers the request.
// A write completes on its grant; read data arrives on a later DC_RVALID.
module amo_unit
    import amo_unit_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter int RES_GRAN_LOG2 = 3
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            AMO_VALID,
    input  logic [4:0]      AMO_OP,
    input  logic            OP_32,
    input  logic [XLEN-1:0] ADDR,
    input  logic [XLEN-1:0] RS2,
    output logic            BUSY,
    output logic            RESULT_VALID,
    output logic [XLEN-1:0] RESULT,
    output logic            MISALIGN,
    output logic            ILLEGAL,
    output logic            DC_REQ,
    output logic            DC_WE,
    output logic [XLEN-1:0] DC_ADDR,
    output logic [1:0]      DC_SIZE,
    output logic [XLEN-1:0] DC_WDATA,
    input  logic            DC_GNT,
    input  logic            DC_RVALID,
    input  logic [XLEN-1:0] DC_RDATA,
    input  logic            SNOOP_VALID,
    input  logic [XLEN-1:0] SNOOP_ADDR,
    input  logic            RES_CLEAR,
    output logic [2:0]      DBG_STATE
);

    amo_state_e state;
    amo_state_e state_next;

    logic [4:0]      op_q;
    logic            op32_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] wdata_q;
    logic            misalign_q;
    logic            illegal_q;

    logic                          res_valid;
    logic [XLEN-1:RES_GRAN_LOG2]   res_granule;

    logic            accept;
    logic            misaligned_in;
    logic            supported_in;
    logic            snoop_hit_res;
    logic            snoop_hit_new;
    logic            sc_hit;
    logic            sc_accept;
    logic            load_done;
    logic            res_set;
    logic [31:0]     rdata_word;
    logic [XLEN-1:0] rdata_sel;
    logic [XLEN-1:0] alu_new;
    logic            unused_snoop_low;

    assign unused_snoop_low = ^SNOOP_ADDR[RES_GRAN_LOG2-1:0];

    // Request decode and reservation lookup, evaluated only in IDLE
    always_comb begin
        accept        = (state == S_IDLE) && AMO_VALID;
        misaligned_in = OP_32 ? (ADDR[1:0] != 2'b00) : (ADDR[2:0] != 3'b000);
        supported_in  = is_supported(AMO_OP);
        snoop_hit_res = SNOOP_VALID && res_valid &&
                        (SNOOP_ADDR[XLEN-1:RES_GRAN_LOG2] == res_granule);
        snoop_hit_new = SNOOP_VALID &&
                        (SNOOP_ADDR[XLEN-1:RES_GRAN_LOG2] == addr_q[XLEN-1:RES_GRAN_LOG2]);
        // A snoop or clear arriving with the SC kills the reservation first
        sc_hit        = res_valid && !snoop_hit_res && !RES_CLEAR &&
                        (ADDR[XLEN-1:RES_GRAN_LOG2] == res_granule);
        sc_accept     = accept && !misaligned_in && (AMO_OP == AMO_SC);
        load_done     = (state == S_RWAIT) && DC_RVALID;
        res_set       = load_done && (op_q == AMO_LR);
    end

    // Load alignment: a word is picked from the doubleword and sign-extended
    always_comb begin
        rdata_word = addr_q[2] ? DC_RDATA[63:32] : DC_RDATA[31:0];
        rdata_sel  = op32_q ? {{(XLEN-32){rdata_word[31]}}, rdata_word} : DC_RDATA;
    end

    amo_alu #(.XLEN(XLEN)) u_alu (
        .op      (op_q),
        .op_32   (op32_q),
        .loaded  (rdata_sel),
        .rs2     (rs2_q),
        .new_val (alu_new)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (AMO_VALID) begin
                    if (misaligned_in || !supported_in) state_next = S_DONE;
                    else if (AMO_OP == AMO_SC)          state_next = sc_hit ? S_WR : S_DONE;
                    else                                state_next = S_RD;
                end
            end
            S_RD:    if (DC_GNT) state_next = S_RWAIT;
            S_RWAIT: if (DC_RVALID) state_next = (op_q == AMO_LR) ? S_DONE : S_WR;
            S_WR:    if (DC_GNT) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Operand capture, result and write-data registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q       <= 5'd0;
            op32_q     <= 1'b0;
            addr_q     <= '0;
            rs2_q      <= '0;
            result_q   <= '0;
            wdata_q    <= '0;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (accept) begin
            op_q       <= AMO_OP;
            op32_q     <= OP_32;
            addr_q     <= ADDR;
            rs2_q      <= RS2;
            misalign_q <= misaligned_in;
            illegal_q  <= !misaligned_in && !supported_in;
            // SC reports 0 on success, 1 on failure; faults report 0
            result_q   <= {{(XLEN-1){1'b0}},
                           (!misaligned_in && (AMO_OP == AMO_SC) && !sc_hit)};
            wdata_q    <= RS2;
        end else if (load_done) begin
            result_q   <= rdata_sel;
            wdata_q    <= alu_new;
        end
    end

    // Reservation: clears take priority over a same-cycle LR set
    always_ff @(posedge CLK) begin
        if (RST) begin
            res_valid   <= 1'b0;
            res_granule <= '0;
        end else if (res_set) begin
            res_granule <= addr_q[XLEN-1:RES_GRAN_LOG2];
            res_valid   <= !(RES_CLEAR || snoop_hit_new);
        end else if (RES_CLEAR || snoop_hit_res || sc_accept) begin
            res_valid   <= 1'b0;
        end
    end

    // Output decode; cache fields are zero whenever no request is pending
    always_comb begin
        BUSY         = (state != S_IDLE);
        RESULT_VALID = (state == S_DONE);
        RESULT       = result_q;
        MISALIGN     = misalign_q;
        ILLEGAL      = illegal_q;
        DC_REQ       = (state == S_RD) || (state == S_WR);
        DC_WE        = (state == S_WR);
        DC_ADDR      = DC_REQ ? addr_q : '0;
        DC_SIZE      = DC_REQ ? (op32_q ? DC_SIZE_W : DC_SIZE_D) : 2'd0;
        DC_WDATA     = '0;
        if (state == S_WR)
            DC_WDATA = op32_q ? {wdata_q[31:0], wdata_q[31:0]} : wdata_q;
        DBG_STATE    = state;
    end

endmodule
